phase_accum: RTL and testbench
==============================

PHASE_ACCUM -- requirements
Module: phase_accum

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: width of the sine-ROM address output.
REQ-002 Parameter ACC_WIDTH, default 16: phase accumulator width; SHALL be at least ADDRESS_WIDTH.
REQ-003 Parameter INIT_INCR, default 256: increment loaded at reset, giving one address step per cycle at defaults.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  level enable; high = accumulate, low = hold phase.
REQ-007 phase_clr  in  1  synchronous phase clear, one-cycle effect.
REQ-008 incr  in  ACC_WIDTH  new phase increment (frequency word).
REQ-009 incr_valid  in  1  incr is offered this cycle.
REQ-010 incr_ready  out  1  block can accept incr; SHALL be the inverse of pending.
REQ-011 addr  out  ADDRESS_WIDTH  ROM address = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH].
REQ-012 wrap  out  1  one-cycle pulse: the accumulator carried out on the previous edge.
REQ-013 pending  out  1  an accepted increment is waiting for a wrap.

Function
REQ-014 addr and wrap SHALL be driven from registers only, with no combinational path from any input.
REQ-015 The FSM SHALL have three states, IDLE, RUN and PEND; pending = (state == PEND).
REQ-016 IDLE->RUN when en=1; RUN/PEND->IDLE when en=0, and any pending increment SHALL be applied on that edge.
REQ-017 In RUN or PEND: acc <= acc + incr_reg, modulo 2^ACC_WIDTH; the carry-out sets wrap on the same edge.
REQ-018 In IDLE: acc SHALL hold and wrap SHALL be 0.
REQ-019 Handshake: a transfer occurs on an edge where incr_valid && incr_ready; incr is captured into a pending register.
REQ-020 Transfer while in IDLE: incr_reg <= incr on the same edge; state stays IDLE and incr_ready stays 1.
REQ-021 Transfer while in RUN: state -> PEND.
REQ-022 In PEND, on the edge where the add carries out, the sum SHALL use the old incr_reg, then incr_reg <= pending value and state -> RUN.
REQ-023 Consequence of REQ-022: the new step size takes effect starting at addr 0, with no phase discontinuity.
REQ-024 Transfer while in RUN with incr_reg == 0: applied immediately, no PEND, since a wrap can never occur.
REQ-025 phase_clr=1 (en any): acc <= 0 and wrap <= 0; a pending increment SHALL be applied on that edge and the state leaves PEND.
REQ-026 phase_clr and a transfer on the same edge: acc <= 0 and incr_reg <= incr, applied immediately.
REQ-027 incr_valid held while incr_ready=0 SHALL be ignored; the master holds incr until accepted.

Reset
REQ-028 While rst_n=0: acc=0, addr=0, wrap=0, incr_reg=INIT_INCR, pending register=0, state=IDLE, incr_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard any pending increment immediately, without waiting for a clock edge.
REQ-030 The first accumulate SHALL occur on the first rising edge after rst_n deasserts with en=1.

Structure
REQ-031 Package phase_accum_pkg SHALL hold the FSM state enum typedef and the INIT_INCR default constant.
REQ-032 No sub-module: phase_accum is flat; the top level connects addr directly to the sine ROM addr port.

Verification
REQ-033 Reset, en=1, defaults -> addr 1,2,...,255,0,1; wrap=1 only in the cycle addr=0; period 256 cycles.
REQ-034 IDLE, load incr=128, then en=1 -> incr_ready stays 1; addr advances by 1 every 2 cycles; first wrap after 512 cycles.
REQ-035 Running at 256, load incr=512 when addr=10 -> incr_ready=0 and pending=1; addr steps by 1 up to 255, then 0,2,4; incr_ready=1 from the cycle addr=0.
REQ-036 Running, phase_clr pulse at addr=77 -> next cycle addr=0, wrap=0; accumulation resumes 1,2,...
REQ-037 en=0 at addr=40 -> addr holds at 40; load incr=768 -> applied immediately; en=1 -> addr 43,46.
REQ-038 rst_n pulsed low while pending=1 at addr=200 -> addr=0, pending=0, incr_ready=1 asynchronously; after release, step size is 1 again.

Source files
------------

// File: rtl/phase_accum_pkg.sv
// Shared types and constants for the phase accumulator.
// The FSM state enum and the reset value of the increment live here.
package phase_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } phase_state_e;

  localparam int INIT_INCR_DEFAULT = 256;

endpackage

// File: rtl/phase_accum.sv
// DDS phase accumulator that drives a sine-ROM address.
// New frequency words are deferred to the next wrap, so the new step starts at addr 0.
module phase_accum
  import phase_accum_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int ACC_WIDTH     = 16,
  parameter int INIT_INCR     = INIT_INCR_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     phase_clr,
  input  logic [ACC_WIDTH-1:0]     incr,
  input  logic                     incr_valid,
  output logic                     incr_ready,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     wrap,
  output logic                     pending,
  output phase_state_e             fsm_state
);

  // Handshake: incr is transferred on a rising edge where incr_valid && incr_ready;
  // incr_ready depends only on state, and a master holds incr until it is accepted.

  phase_state_e         state, state_next;
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic [ACC_WIDTH-1:0] incr_reg, incr_reg_next;
  logic [ACC_WIDTH-1:0] pend_reg, pend_reg_next;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;
  logic                 wrap_next;
  logic                 xfer;

  assign incr_ready   = (state != ST_PEND);
  assign pending      = (state == ST_PEND);
  assign fsm_state    = state;
  assign xfer         = incr_valid && incr_ready;
  assign {carry, sum} = {1'b0, acc} + {1'b0, incr_reg};
  assign addr         = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];

  always_comb begin
    state_next    = state;
    acc_next      = acc;
    wrap_next     = 1'b0;
    incr_reg_next = incr_reg;
    pend_reg_next = pend_reg;

    if (phase_clr || !en) begin
      // Leaving the accumulate path: flush any deferred word, and take a new one directly.
      if (state == ST_PEND) incr_reg_next = pend_reg;
      if (xfer)             incr_reg_next = incr;
      if (phase_clr)        acc_next      = '0;
      state_next = (phase_clr && en) ? ST_RUN : ST_IDLE;
    end else begin
      acc_next  = sum;
      wrap_next = carry;
      case (state)
        ST_IDLE: begin
          if (xfer) incr_reg_next = incr;
          state_next = ST_RUN;
        end
        ST_RUN: begin
          // A zero step never wraps, so deferring it would stall forever.
          if (xfer) begin
            if (incr_reg == '0) begin
              incr_reg_next = incr;
            end else begin
              pend_reg_next = incr;
              state_next    = ST_PEND;
            end
          end
        end
        ST_PEND: begin
          if (carry) begin
            incr_reg_next = pend_reg;
            state_next    = ST_RUN;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc      <= '0;
      wrap     <= 1'b0;
      incr_reg <= ACC_WIDTH'(INIT_INCR);
      pend_reg <= '0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      wrap     <= wrap_next;
      incr_reg <= incr_reg_next;
      pend_reg <= pend_reg_next;
    end
  end

endmodule

// File: tb/tb_phase_accum.sv
// Directed bench for phase_accum: an integer phase model checked every cycle,
// plus hand-computed address/wrap expectations for each scenario.
module tb_phase_accum;
  import phase_accum_pkg::*;

  localparam int AW = 8;
  localparam int W  = 16;
  localparam longint MOD = 65536;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          en, phase_clr, incr_valid;
  logic [W-1:0]  incr;
  logic          incr_ready, wrap, pending;
  logic [AW-1:0] addr;
  phase_state_e  fsm_state;

  phase_accum #(.ADDRESS_WIDTH(AW), .ACC_WIDTH(W), .INIT_INCR(256)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
    .incr(incr), .incr_valid(incr_valid), .incr_ready(incr_ready),
    .addr(addr), .wrap(wrap), .pending(pending), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // behavioural model: phase as an integer modulo 2^W
  longint m_phase = 0;
  longint m_step  = 256;
  longint m_queued = 0;
  bit     m_pend = 0;
  bit     m_run  = 0;
  bit     m_wrap = 0;

  task automatic model_reset();
    m_phase = 0; m_step = 256; m_queued = 0; m_pend = 0; m_run = 0; m_wrap = 0;
  endtask

  task automatic model_edge();
    bit     take;
    longint s;
    take = incr_valid && !m_pend;
    if (phase_clr || !en) begin
      if (m_pend) m_step = m_queued;
      m_pend = 0;
      if (take) m_step = longint'(incr);
      if (phase_clr) m_phase = 0;
      m_wrap = 0;
      m_run  = en;
    end else begin
      s = m_phase + m_step;
      m_wrap  = (s >= MOD);
      m_phase = s % MOD;
      if (m_pend && m_wrap) begin
        m_step = m_queued;
        m_pend = 0;
      end else if (take) begin
        if (!m_run || m_step == 0) m_step = longint'(incr);
        else begin
          m_queued = longint'(incr);
          m_pend   = 1;
        end
      end
      m_run = 1;
    end
  endtask

  // scoreboard compare, every cycle and on asynchronous reset
  always @(posedge clk or negedge rst_n) begin
    phase_state_e exp_st;
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    exp_st = m_pend ? ST_PEND : (m_run ? ST_RUN : ST_IDLE);
    check("cyc_addr", addr, m_phase >> (W - AW));
    check("cyc_wrap", wrap, m_wrap);
    check("cyc_pending", pending, m_pend);
    check("cyc_incr_ready", incr_ready, !m_pend);
    check("cyc_state", fsm_state, exp_st);
  end

  // driver tasks
  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(logic [W-1:0] v);
    incr = v;
    incr_valid = 1'b1;
    @(negedge clk);
    incr_valid = 1'b0;
  endtask

  task automatic clear_and_load(logic [W-1:0] v);
    en = 1'b0;
    phase_clr = 1'b1;
    incr = v;
    incr_valid = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    incr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_wrap;
    bit found;
    rst_n = 1'b0; en = 1'b0; phase_clr = 1'b0; incr = '0; incr_valid = 1'b0;
    cycles(3);
    check("rst_addr", addr, 0);
    check("rst_wrap", wrap, 0);
    check("rst_pending", pending, 0);
    check("rst_incr_ready", incr_ready, 1);

    // defaults: one address step per cycle, period 256
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      check("run_addr", addr, k % 256);
      check("run_wrap", wrap, (k % 256) == 0);
    end

    // hold at 40, load 768 while idle, resume at 3 per cycle
    cycles(39);
    check("hold_pre_addr", addr, 40);
    en = 1'b0;
    @(negedge clk);
    check("hold_addr", addr, 40);
    xfer(16'd768);
    check("idle_load_ready", incr_ready, 1);
    check("idle_load_addr", addr, 40);
    en = 1'b1;
    @(negedge clk);
    check("resume_addr0", addr, 43);
    @(negedge clk);
    check("resume_addr1", addr, 46);

    // clear + load 128 on one edge, then half-rate with wrap after 512 cycles
    clear_and_load(16'd128);
    check("clr_load_addr", addr, 0);
    en = 1'b1;
    found = 0;
    first_wrap = 0;
    for (int i = 1; i <= 600 && !found; i++) begin
      @(negedge clk);
      if (i == 1) check("half_addr1", addr, 0);
      if (i == 2) check("half_addr2", addr, 1);
      if (wrap) begin
        found = 1;
        first_wrap = i;
      end
    end
    check("half_first_wrap", first_wrap, 512);

    // deferred increment takes effect at the wrap
    clear_and_load(16'd256);
    en = 1'b1;
    cycles(10);
    check("pend_pre_addr", addr, 10);
    xfer(16'd512);
    check("pend_addr", addr, 11);
    check("pend_flag", pending, 1);
    check("pend_ready", incr_ready, 0);
    incr = 16'd1024;
    incr_valid = 1'b1;
    cycles(5);
    incr_valid = 1'b0;
    check("pend_ignore_addr", addr, 16);
    check("pend_ignore_flag", pending, 1);
    cycles(239);
    check("pend_last_addr", addr, 255);
    @(negedge clk);
    check("pend_wrap_addr", addr, 0);
    check("pend_wrap_wrap", wrap, 1);
    check("pend_wrap_ready", incr_ready, 1);
    @(negedge clk);
    check("new_step_addr2", addr, 2);
    @(negedge clk);
    check("new_step_addr4", addr, 4);
    check("new_step_wrap", wrap, 0);

    // phase clear while running
    clear_and_load(16'd256);
    en = 1'b1;
    cycles(77);
    check("clr_pre_addr", addr, 77);
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    check("clr_addr", addr, 0);
    check("clr_wrap", wrap, 0);
    @(negedge clk);
    check("clr_resume1", addr, 1);
    @(negedge clk);
    check("clr_resume2", addr, 2);

    // asynchronous reset discards a pending increment
    cycles(197);
    check("areset_pre_addr", addr, 199);
    xfer(16'd512);
    check("areset_pend_addr", addr, 200);
    check("areset_pend_flag", pending, 1);
    #2;
    rst_n = 1'b0;
    #2;
    check("areset_addr", addr, 0);
    check("areset_pending", pending, 0);
    check("areset_ready", incr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_addr1", addr, 1);
    @(negedge clk);
    check("post_reset_addr2", addr, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
